issue_queue_wb: RTL and testbench

Parametrised successor to the single-entry-write issue queue. It accepts one renamed instruction per cycle from dispatch and holds it in a reservation-station slot. It captures source operands from multiple writeback (CDB) ports. Each cycle it selects up to ISSUE_PORTS ready entries to issue to the functional units. It sits between rename/dispatch and the execute stage, with ROB-indexed entries and a full-queue flush.

---
 rtl/issue_queue_wb.sv | 264 ++++++++++++++++++++++++++
 tb/tb_issue_queue_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_wb.sv
// issue_queue_wb: reservation-station issue queue. Accepts one renamed instruction per
// cycle, captures operands from several writeback ports, and issues up to ISSUE_PORTS
// ready entries per cycle through registered outputs.
module issue_queue_wb #(
    parameter int unsigned IQ_SIZE     = 16,
    parameter int unsigned ISSUE_PORTS = 2,
    parameter int unsigned WB_PORTS    = 2,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROB_W       = 4,
    parameter int unsigned OP_W        = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_issue_stall,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [OP_W-1:0]                 i_in_op,
    input  logic [ROB_W-1:0]                i_in_rob,
    input  logic [TAG_W-1:0]                i_in_prd,
    input  logic [TAG_W-1:0]                i_in_prs1,
    input  logic [TAG_W-1:0]                i_in_prs2,
    input  logic                            i_in_rs1_rdy,
    input  logic                            i_in_rs2_rdy,
    input  logic [DATA_W-1:0]               i_in_rs1_data,
    input  logic [DATA_W-1:0]               i_in_rs2_data,
    input  logic                            i_in_imm_en,
    input  logic [DATA_W-1:0]               i_in_imm,
    input  logic [WB_PORTS-1:0]             i_wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]       i_wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]      i_wb_data,
    output logic [ISSUE_PORTS-1:0]          o_out_valid,
    output logic [ISSUE_PORTS*OP_W-1:0]     o_out_op,
    output logic [ISSUE_PORTS*ROB_W-1:0]    o_out_rob,
    output logic [ISSUE_PORTS*TAG_W-1:0]    o_out_prd,
    output logic [ISSUE_PORTS*DATA_W-1:0]   o_out_src1,
    output logic [ISSUE_PORTS*DATA_W-1:0]   o_out_src2,
    output logic [$clog2(IQ_SIZE):0]        o_count
);

    localparam int unsigned IDX_W = $clog2(IQ_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_SIZE);

    // Entry storage
    logic [IQ_SIZE-1:0] r_valid;
    logic [OP_W-1:0]    r_op    [IQ_SIZE];
    logic [ROB_W-1:0]   r_rob   [IQ_SIZE];
    logic [TAG_W-1:0]   r_prd   [IQ_SIZE];
    logic [TAG_W-1:0]   r_tag1  [IQ_SIZE];
    logic [TAG_W-1:0]   r_tag2  [IQ_SIZE];
    logic [IQ_SIZE-1:0] r_rdy1;
    logic [IQ_SIZE-1:0] r_rdy2;
    logic [DATA_W-1:0]  r_data1 [IQ_SIZE];
    logic [DATA_W-1:0]  r_data2 [IQ_SIZE];
    logic [CNT_W-1:0]   r_count;

    // Registered issue outputs
    logic [ISSUE_PORTS-1:0]        r_out_valid;
    logic [ISSUE_PORTS*OP_W-1:0]   r_out_op;
    logic [ISSUE_PORTS*ROB_W-1:0]  r_out_rob;
    logic [ISSUE_PORTS*TAG_W-1:0]  r_out_prd;
    logic [ISSUE_PORTS*DATA_W-1:0] r_out_src1;
    logic [ISSUE_PORTS*DATA_W-1:0] r_out_src2;

    logic                    w_in_ready;
    logic                    w_disp;
    logic                    w_free_found;
    logic [IDX_W-1:0]        w_free_idx;
    logic                    w_d_rdy1;
    logic                    w_d_rdy2;
    logic [DATA_W-1:0]       w_d_data1;
    logic [DATA_W-1:0]       w_d_data2;
    logic [IQ_SIZE-1:0]      w_wk1;
    logic [IQ_SIZE-1:0]      w_wk2;
    logic [DATA_W-1:0]       w_wk1_data [IQ_SIZE];
    logic [DATA_W-1:0]       w_wk2_data [IQ_SIZE];
    logic [IQ_SIZE-1:0]      w_eligible;
    logic [IQ_SIZE-1:0]      w_taken;
    logic [ISSUE_PORTS-1:0]  w_sel_valid;
    logic [IDX_W-1:0]        w_sel_idx [ISSUE_PORTS];
    logic [CNT_W-1:0]        w_n_issue;

    // Occupancy-based ready: a slot freed by issue this cycle is not reusable until next cycle
    assign w_in_ready = (r_count < FULL_CNT);
    assign w_disp     = i_in_valid && w_in_ready && !i_flush;

    // Lowest-index free slot for dispatch
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch source readiness: wb bypass, overridden by tag 0, overridden by regfile/immediate
    always_comb begin
        w_d_rdy1  = 1'b0;
        w_d_rdy2  = 1'b0;
        w_d_data1 = '0;
        w_d_data2 = '0;
        // Descending scan so the lowest matching port is applied last and wins
        for (int w = WB_PORTS - 1; w >= 0; w--) begin
            if (i_wb_valid[w] && (i_wb_tag[w*TAG_W +: TAG_W] != '0)) begin
                if (i_wb_tag[w*TAG_W +: TAG_W] == i_in_prs1) begin
                    w_d_rdy1  = 1'b1;
                    w_d_data1 = i_wb_data[w*DATA_W +: DATA_W];
                end
                if (i_wb_tag[w*TAG_W +: TAG_W] == i_in_prs2) begin
                    w_d_rdy2  = 1'b1;
                    w_d_data2 = i_wb_data[w*DATA_W +: DATA_W];
                end
            end
        end
        if (i_in_prs1 == '0) begin
            w_d_rdy1  = 1'b1;
            w_d_data1 = '0;
        end
        if (i_in_rs1_rdy) begin
            w_d_rdy1  = 1'b1;
            w_d_data1 = i_in_rs1_data;
        end
        if (i_in_prs2 == '0) begin
            w_d_rdy2  = 1'b1;
            w_d_data2 = '0;
        end
        if (i_in_rs2_rdy) begin
            w_d_rdy2  = 1'b1;
            w_d_data2 = i_in_rs2_data;
        end
        if (i_in_imm_en) begin
            w_d_rdy2  = 1'b1;
            w_d_data2 = i_in_imm;
        end
    end

    // Wakeup match of every stored source tag against the writeback ports
    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            w_wk1[i]      = 1'b0;
            w_wk2[i]      = 1'b0;
            w_wk1_data[i] = '0;
            w_wk2_data[i] = '0;
            for (int w = WB_PORTS - 1; w >= 0; w--) begin
                if (i_wb_valid[w] && (i_wb_tag[w*TAG_W +: TAG_W] != '0)) begin
                    if (i_wb_tag[w*TAG_W +: TAG_W] == r_tag1[i]) begin
                        w_wk1[i]      = 1'b1;
                        w_wk1_data[i] = i_wb_data[w*DATA_W +: DATA_W];
                    end
                    if (i_wb_tag[w*TAG_W +: TAG_W] == r_tag2[i]) begin
                        w_wk2[i]      = 1'b1;
                        w_wk2_data[i] = i_wb_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Select: port p takes the p-th lowest eligible entry. Issued entries are invalidated
    // at the issuing edge, so "not issued last cycle" holds without extra state.
    always_comb begin
        w_eligible = '0;
        if (!i_issue_stall && !i_flush) begin
            w_eligible = r_valid & r_rdy1 & r_rdy2;
        end
        w_taken   = '0;
        w_n_issue = '0;
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            w_sel_valid[p] = 1'b0;
            w_sel_idx[p]   = '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (!w_sel_valid[p] && w_eligible[i] && !w_taken[i]) begin
                    w_sel_valid[p] = 1'b1;
                    w_sel_idx[p]   = IDX_W'(i);
                    w_taken[i]     = 1'b1;
                end
            end
            w_n_issue = w_n_issue + CNT_W'(w_sel_valid[p]);
        end
    end

    // Entry state: flush/reset clear, issue invalidates, wakeup captures, dispatch writes
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (w_taken[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (r_valid[i] && !r_rdy1[i] && w_wk1[i]) begin
                    r_rdy1[i]  <= 1'b1;
                    r_data1[i] <= w_wk1_data[i];
                end
                if (r_valid[i] && !r_rdy2[i] && w_wk2[i]) begin
                    r_rdy2[i]  <= 1'b1;
                    r_data2[i] <= w_wk2_data[i];
                end
            end
            // The free slot is never valid, so this cannot collide with wakeup or issue
            if (w_disp && w_free_found) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= i_in_op;
                r_rob[w_free_idx]   <= i_in_rob;
                r_prd[w_free_idx]   <= i_in_prd;
                r_tag1[w_free_idx]  <= i_in_prs1;
                r_tag2[w_free_idx]  <= i_in_imm_en ? '0 : i_in_prs2;
                r_rdy1[w_free_idx]  <= w_d_rdy1;
                r_rdy2[w_free_idx]  <= w_d_rdy2;
                r_data1[w_free_idx] <= w_d_data1;
                r_data2[w_free_idx] <= w_d_data2;
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_disp) - w_n_issue;
        end
    end

    // Issue output registers; fields of idle ports hold their last value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= '0;
            r_out_op    <= '0;
            r_out_rob   <= '0;
            r_out_prd   <= '0;
            r_out_src1  <= '0;
            r_out_src2  <= '0;
        end else if (i_flush) begin
            r_out_valid <= '0;
        end else begin
            r_out_valid <= w_sel_valid;
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                if (w_sel_valid[p]) begin
                    r_out_op[p*OP_W +: OP_W]       <= r_op[w_sel_idx[p]];
                    r_out_rob[p*ROB_W +: ROB_W]    <= r_rob[w_sel_idx[p]];
                    r_out_prd[p*TAG_W +: TAG_W]    <= r_prd[w_sel_idx[p]];
                    r_out_src1[p*DATA_W +: DATA_W] <= r_data1[w_sel_idx[p]];
                    r_out_src2[p*DATA_W +: DATA_W] <= r_data2[w_sel_idx[p]];
                end
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_count     = r_count;
    assign o_out_valid = r_out_valid;
    assign o_out_op    = r_out_op;
    assign o_out_rob   = r_out_rob;
    assign o_out_prd   = r_out_prd;
    assign o_out_src1  = r_out_src1;
    assign o_out_src2  = r_out_src2;

endmodule

// File: tb/tb_issue_queue_wb.sv
// Directed bench for issue_queue_wb with default parameters (16 entries, 2 issue, 2 wb).
module tb_issue_queue_wb;

    logic        clk = 1'b0;
    logic        rst, flush, stall, in_valid, in_ready;
    logic [4:0]  in_op;
    logic [3:0]  in_rob;
    logic [5:0]  in_prd, in_prs1, in_prs2;
    logic        rs1_rdy, rs2_rdy, imm_en;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [63:0] wb_data;
    logic [1:0]  out_valid;
    logic [9:0]  out_op;
    logic [7:0]  out_rob;
    logic [11:0] out_prd;
    logic [63:0] out_src1, out_src2;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    issue_queue_wb dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_issue_stall(stall),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op), .i_in_rob(in_rob),
        .i_in_prd(in_prd), .i_in_prs1(in_prs1), .i_in_prs2(in_prs2),
        .i_in_rs1_rdy(rs1_rdy), .i_in_rs2_rdy(rs2_rdy),
        .i_in_rs1_data(rs1_data), .i_in_rs2_data(rs2_data),
        .i_in_imm_en(imm_en), .i_in_imm(imm),
        .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_data(wb_data),
        .o_out_valid(out_valid), .o_out_op(out_op), .o_out_rob(out_rob),
        .o_out_prd(out_prd), .o_out_src1(out_src1), .o_out_src2(out_src2),
        .o_count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; imm_en = 1'b0; imm = '0; flush = 1'b0;
        wb_valid = '0; wb_tag = '0; wb_data = '0;
    endtask

    // op = rob+1, prd = {2'b01, rob}
    task automatic disp(input logic [3:0] rob, input logic [5:0] p1, input logic r1,
                        input logic [31:0] d1, input logic [5:0] p2, input logic r2,
                        input logic [31:0] d2);
        in_valid = 1'b1; in_rob = rob; in_op = {1'b0, rob} + 5'd1; in_prd = {2'b01, rob};
        in_prs1 = p1; rs1_rdy = r1; rs1_data = d1;
        in_prs2 = p2; rs2_rdy = r2; rs2_data = d2;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; idle();
        in_op = '0; in_rob = '0; in_prd = '0; in_prs1 = '0; in_prs2 = '0;
        rs1_rdy = 1'b0; rs2_rdy = 1'b0; rs1_data = '0; rs2_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rob", 64'(out_rob), 64'd0);
        chk("rst_src1", out_src1, 64'd0);

        // Three ready entries held by stall, then two issue together, then one
        stall = 1'b1;
        disp(4'd1, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h21); tick();
        disp(4'd2, 6'd3, 1'b1, 32'h12, 6'd4, 1'b1, 32'h22); tick();
        disp(4'd3, 6'd5, 1'b1, 32'h13, 6'd6, 1'b1, 32'h23); tick();
        idle();
        chk("three_count", 64'(count), 64'd3);
        chk("three_stalled", 64'(out_valid), 64'd0);
        stall = 1'b0;
        tick();
        chk("dual_valid", 64'(out_valid), 64'b11);
        chk("dual_rob", 64'(out_rob), 64'h21);
        chk("dual_src1", out_src1, 64'h00000012_00000011);
        chk("dual_src2", out_src2, 64'h00000022_00000021);
        chk("dual_count", 64'(count), 64'd1);
        tick();
        chk("third_valid", 64'(out_valid), 64'b01);
        chk("third_rob", 64'(out_rob[3:0]), 64'd3);
        chk("third_count", 64'(count), 64'd0);
        tick();
        chk("third_once", 64'(out_valid), 64'd0);

        // Two-cycle dispatch-to-issue latency
        disp(4'd4, 6'd1, 1'b1, 32'hA, 6'd2, 1'b1, 32'hB); tick(); idle();
        chk("lat_n", 64'(out_valid), 64'd0);
        chk("lat_count", 64'(count), 64'd1);
        tick();
        chk("lat_valid", 64'(out_valid), 64'b01);
        chk("lat_rob", 64'(out_rob[3:0]), 64'd4);
        chk("lat_op", 64'(out_op[4:0]), 64'd5);
        chk("lat_prd", 64'(out_prd[5:0]), 64'h14);
        chk("lat_count0", 64'(count), 64'd0);
        tick();
        chk("lat_once", 64'(out_valid), 64'd0);

        // Wakeup via CDB; both ports carry tag 12, port 0 must win
        disp(4'd5, 6'd12, 1'b0, 32'h0, 6'd2, 1'b1, 32'h5); tick(); idle(); tick();
        chk("wk_wait", 64'(out_valid), 64'd0);
        wb_valid = 2'b11; wb_tag = {6'd12, 6'd12}; wb_data = {32'h00000BAD, 32'hDEADBEEF};
        tick(); idle();
        chk("wk_edge", 64'(out_valid), 64'd0);
        tick();
        chk("wk_valid", 64'(out_valid), 64'b01);
        chk("wk_src1", 64'(out_src1[31:0]), 64'hDEADBEEF);
        chk("wk_rob", 64'(out_rob[3:0]), 64'd5);
        chk("wk_count", 64'(count), 64'd0);

        // Same-cycle bypass from wb port 1
        disp(4'd6, 6'd1, 1'b1, 32'h1, 6'd7, 1'b0, 32'h0);
        wb_valid = 2'b10; wb_tag = {6'd7, 6'd0}; wb_data = {32'h55, 32'h0};
        tick(); idle();
        chk("byp_count", 64'(count), 64'd1);
        tick();
        chk("byp_valid", 64'(out_valid), 64'b01);
        chk("byp_src2", 64'(out_src2[31:0]), 64'h55);

        // Immediate src2 with unready tag 9; src1 tag 0 reads as zero
        disp(4'd7, 6'd0, 1'b0, 32'hFFFF, 6'd9, 1'b0, 32'h0);
        imm_en = 1'b1; imm = 32'h99;
        tick(); idle(); tick();
        chk("imm_valid", 64'(out_valid), 64'b01);
        chk("imm_src1", 64'(out_src1[31:0]), 64'd0);
        chk("imm_src2", 64'(out_src2[31:0]), 64'h99);

        // Fill all 16 slots with src1 waiting on tags 32..47
        for (int i = 0; i < 16; i++) begin
            disp(4'(i), 6'(32 + i), 1'b0, 32'h0, 6'd2, 1'b1, 32'(i));
            tick();
        end
        idle();
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(in_ready), 64'd0);
        disp(4'd9, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2); tick(); idle();
        chk("full_ign_count", 64'(count), 64'd16);
        tick();
        chk("full_ign_valid", 64'(out_valid), 64'd0);
        wb_valid = 2'b01; wb_tag = {6'd0, 6'd37}; wb_data = {32'h0, 32'h5555};
        tick(); idle();
        chk("full_wk_ready", 64'(in_ready), 64'd0);
        chk("full_wk_valid", 64'(out_valid), 64'd0);
        tick();
        chk("full_iss_valid", 64'(out_valid), 64'b01);
        chk("full_iss_rob", 64'(out_rob[3:0]), 64'd5);
        chk("full_iss_src1", 64'(out_src1[31:0]), 64'h5555);
        chk("full_iss_count", 64'(count), 64'd15);
        chk("full_iss_ready", 64'(in_ready), 64'd1);
        disp(4'd14, 6'd1, 1'b1, 32'h77, 6'd2, 1'b1, 32'h0); tick(); idle();
        chk("refill_count", 64'(count), 64'd16);
        tick();
        chk("refill_valid", 64'(out_valid), 64'b01);
        chk("refill_rob", 64'(out_rob[3:0]), 64'd14);
        chk("refill_src1", 64'(out_src1[31:0]), 64'h77);
        flush = 1'b1; tick(); idle();
        chk("flfull_count", 64'(count), 64'd0);
        chk("flfull_ready", 64'(in_ready), 64'd1);

        // Flush with 5 entries (last one ready) and a simultaneous dispatch
        for (int i = 0; i < 4; i++) begin
            disp(4'(i), 6'(40 + i), 1'b0, 32'h0, 6'd2, 1'b1, 32'h0);
            tick();
        end
        disp(4'd4, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2); tick(); idle();
        chk("fl5_count", 64'(count), 64'd5);
        flush = 1'b1;
        disp(4'd8, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        tick(); idle();
        chk("fl5_count0", 64'(count), 64'd0);
        chk("fl5_valid", 64'(out_valid), 64'd0);
        tick();
        chk("fl5_dropped", 64'(out_valid), 64'd0);
        chk("fl5_count1", 64'(count), 64'd0);

        // Stall for three cycles with two ready entries, then both issue together
        stall = 1'b1;
        disp(4'd3, 6'd1, 1'b1, 32'h31, 6'd2, 1'b1, 32'h32); tick();
        disp(4'd4, 6'd1, 1'b1, 32'h41, 6'd2, 1'b1, 32'h42); tick(); idle();
        chk("stl_count", 64'(count), 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_hold", 64'(out_valid), 64'd0);
        end
        stall = 1'b0; tick();
        chk("stl_valid", 64'(out_valid), 64'b11);
        chk("stl_rob", 64'(out_rob), 64'h43);
        chk("stl_src1", out_src1, 64'h00000041_00000031);
        chk("stl_count0", 64'(count), 64'd0);

        // Reset mid-operation clears outputs and drops the pending entry
        disp(4'd2, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2); tick(); idle();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_rob", 64'(out_rob), 64'd0);
        chk("mrst_src1", out_src1, 64'd0);
        tick();
        chk("mrst_dropped", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
